// File: rtl/fetch_sequencer_pkg.sv
// Shared core definitions: PC/instruction widths, reset vector, fetch FSM
// encoding and branch opcodes used by fetch, decode and the branch unit.
package fetch_sequencer_pkg;

    localparam int PC_W    = 19;
    localparam int INSTR_W = 32;

    localparam logic [PC_W-1:0] RESET_PC = 19'h00000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    // Unconditional jump and the two conditional branch opcodes.
    localparam logic [4:0] OP_JMP  = 5'b01010;
    localparam logic [4:0] OP_BRC0 = 5'b01011;
    localparam logic [4:0] OP_BRC1 = 5'b01100;

    // Word-addressed sequential successor; wraps at the top of the space.
    function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
        return pc + {{(PC_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// Saturating event counter: counts enabled cycles and sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Increment on enable unless already saturated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {W{1'b0}};
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer and instruction-fetch controller: owns the PC,
// runs the imem req/ack handshake and applies taken-branch redirects from EX.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_i,
    input  logic               br_valid_i,
    input  logic               br_taken_i,
    input  logic [PC_W-1:0]    br_target_i,
    output logic               imem_req_o,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic               if_valid_o,
    output logic [INSTR_W-1:0] if_instr_o,
    output logic [PC_W-1:0]    if_pc_o,
    output logic               flush_o,
    output logic [CNT_W-1:0]   taken_cnt_o
);

    fetch_state_e        r_state;
    logic [PC_W-1:0]     r_pc;
    logic [PC_W-1:0]     r_addr;
    logic                r_req;
    logic                r_valid;
    logic [INSTR_W-1:0]  r_instr;
    logic [PC_W-1:0]     r_if_pc;
    logic                r_flush;

    logic                w_redirect;
    logic                w_out_busy;
    logic                w_req;
    logic                w_accept;

    assign w_redirect = br_valid_i & br_taken_i & (r_state != ST_BOOT);
    assign w_out_busy = r_valid & stall_i;
    // Masking the request while decode holds a live instruction keeps memory
    // from ever returning data into an occupied output register.
    assign w_req      = r_req & ~w_out_busy;
    assign w_accept   = w_req & imem_ack_i;

    // Sequencer FSM together with the PC, request and IF output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
            r_instr <= {INSTR_W{1'b0}};
            r_if_pc <= {PC_W{1'b0}};
            r_flush <= 1'b0;
        end else begin
            r_flush <= w_redirect;
            if (w_redirect) begin
                // r_pc becomes the pending target; a live unacked request must drain first
                r_valid <= 1'b0;
                r_pc    <= br_target_i;
                r_req   <= 1'b1;
                if (w_req && !imem_ack_i) begin
                    r_state <= ST_DRAIN;
                    r_addr  <= r_addr;
                end else begin
                    r_state <= ST_FETCH;
                    r_addr  <= br_target_i;
                end
            end else begin
                case (r_state)
                    ST_BOOT: begin
                        r_state <= ST_FETCH;
                        r_req   <= 1'b1;
                        r_addr  <= r_pc;
                    end
                    ST_FETCH, ST_HOLD: begin
                        if (w_accept) begin
                            r_state <= ST_FETCH;
                            r_instr <= imem_rdata_i;
                            r_if_pc <= r_addr;
                            r_valid <= 1'b1;
                            r_pc    <= pc_next(r_addr);
                            r_addr  <= pc_next(r_addr);
                        end else if (w_out_busy) begin
                            r_state <= ST_HOLD;
                        end else begin
                            r_state <= ST_FETCH;
                            r_valid <= 1'b0;
                        end
                    end
                    ST_DRAIN: begin
                        if (imem_ack_i) begin
                            r_state <= ST_FETCH;
                            r_addr  <= r_pc;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end
                    default: begin
                        r_state <= ST_BOOT;
                        r_req   <= 1'b0;
                        r_valid <= 1'b0;
                        r_pc    <= RESET_PC;
                        r_addr  <= RESET_PC;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_taken_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_redirect),
        .o_count (taken_cnt_o)
    );

    assign imem_req_o  = w_req;
    assign imem_addr_o = r_addr;
    assign if_valid_o  = r_valid;
    assign if_instr_o  = r_instr;
    assign if_pc_o     = r_if_pc;
    assign flush_o     = r_flush;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a random
// run checked against a transaction-level model of the fetch stream.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        br_valid_i;
    logic        br_taken_i;
    logic [18:0] br_target_i;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;

    logic        imem_req_o, if_valid_o, flush_o;
    logic [18:0] imem_addr_o, if_pc_o;
    logic [31:0] if_instr_o;
    logic [15:0] taken_cnt_o;

    logic        req4, valid4, flush4;
    logic [18:0] addr4, pc4;
    logic [31:0] instr4;
    logic [3:0]  cnt4;

    int n_vec = 0;
    int n_err = 0;
    logic ack_en;

    // model state: next fetch address, abandoned request, IF output register
    logic        m_booted;
    logic [18:0] m_pc;
    logic        m_drain;
    logic [18:0] m_drain_addr;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [18:0] m_ifpc;
    logic        m_flush;
    int          m_cnt;

    fetch_sequencer #(.CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .br_valid_i(br_valid_i),
        .br_taken_i(br_taken_i), .br_target_i(br_target_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
        .if_valid_o(if_valid_o), .if_instr_o(if_instr_o), .if_pc_o(if_pc_o),
        .flush_o(flush_o), .taken_cnt_o(taken_cnt_o)
    );

    fetch_sequencer #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .br_valid_i(br_valid_i),
        .br_taken_i(br_taken_i), .br_target_i(br_target_i),
        .imem_req_o(req4), .imem_addr_o(addr4),
        .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
        .if_valid_o(valid4), .if_instr_o(instr4), .if_pc_o(pc4),
        .flush_o(flush4), .taken_cnt_o(cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [18:0] a);
        return {a[12:0] ^ 13'h1A5B, a};
    endfunction

    function automatic logic exp_req();
        if (!m_booted) return 1'b0;
        if (m_drain) return 1'b1;
        return !(m_valid && stall_i);
    endfunction

    function automatic logic [18:0] exp_addr();
        if (!m_booted) return 19'h00000;
        return m_drain ? m_drain_addr : m_pc;
    endfunction

    function automatic logic [15:0] exp_cnt16();
        return (m_cnt > 65535) ? 16'hFFFF : 16'(m_cnt);
    endfunction

    function automatic logic [3:0] exp_cnt4();
        return (m_cnt > 15) ? 4'hF : 4'(m_cnt);
    endfunction

    task automatic model_reset();
        m_booted = 1'b0; m_pc = 19'h00000; m_drain = 1'b0; m_drain_addr = 19'h0;
        m_valid = 1'b0; m_instr = 32'h0; m_ifpc = 19'h0; m_flush = 1'b0; m_cnt = 0;
    endtask

    task automatic model_step();
        logic req;
        logic redirect;
        req = exp_req();
        redirect = m_booted && br_valid_i && br_taken_i;
        if (!m_booted) begin
            m_booted = 1'b1;
            m_flush = 1'b0;
        end else begin
            m_flush = redirect;
            if (redirect) begin
                m_cnt++;
                m_valid = 1'b0;
                if (req && !ack_en) begin
                    if (!m_drain) m_drain_addr = m_pc;
                    m_drain = 1'b1;
                end else begin
                    m_drain = 1'b0;
                end
                m_pc = br_target_i;
            end else if (m_drain) begin
                if (ack_en) m_drain = 1'b0;
            end else if (req && ack_en) begin
                m_valid = 1'b1;
                m_ifpc = m_pc;
                m_instr = mem_word(m_pc);
                m_pc = m_pc + 19'd1;
            end else if (!(m_valid && stall_i)) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic drive(input logic s, input logic bv, input logic bt,
                         input logic [18:0] tgt, input logic ae);
        stall_i = s; br_valid_i = bv; br_taken_i = bt; br_target_i = tgt; ack_en = ae;
        #1;
        imem_ack_i = imem_req_o & ae;
        imem_rdata_i = mem_word(imem_addr_o);
        #1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 19'h0, 1'b0);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 19'h0, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 19'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        model_reset();
        n_vec++;
        if (imem_req_o !== 1'b0 || imem_addr_o !== 19'h00000 || if_valid_o !== 1'b0 || flush_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: req=%b addr=%h valid=%b flush=%b, want 0/00000/0/0", imem_req_o, imem_addr_o, if_valid_o, flush_o);
        end
        n_vec++;
        if (if_instr_o !== 32'h0 || if_pc_o !== 19'h0 || taken_cnt_o !== 16'h0 || cnt4 !== 4'h0) begin
            n_err++;
            $display("FAIL reset_data: instr=%h pc=%h cnt=%h cnt4=%h, want zeros", if_instr_o, if_pc_o, taken_cnt_o, cnt4);
        end
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 19'h00055, 1'b1);
        n_vec++;
        if (imem_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL boot_hold: req=%b want 0", imem_req_o);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 19'h0, 1'b1);
        n_vec++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 19'h00000 || flush_o !== 1'b0 || taken_cnt_o !== 16'h0) begin
            n_err++;
            $display("FAIL boot_exit: req=%b addr=%h flush=%b cnt=%h, want 1/00000/0/0", imem_req_o, imem_addr_o, flush_o, taken_cnt_o);
        end
    endtask

    task automatic test_seq_fetch();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 1'b0, 19'h0, 1'b1);
            n_vec++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== 19'(k)) begin
                n_err++;
                $display("FAIL seq_addr[%0d]: req=%b addr=%h, want 1/%h", k, imem_req_o, imem_addr_o, 19'(k));
            end
            if (k > 0) begin
                n_vec++;
                if (if_valid_o !== 1'b1 || if_pc_o !== 19'(k-1) || if_instr_o !== mem_word(19'(k-1))) begin
                    n_err++;
                    $display("FAIL seq_out[%0d]: valid=%b pc=%h instr=%h, want 1/%h/%h", k, if_valid_o, if_pc_o, if_instr_o, 19'(k-1), mem_word(19'(k-1)));
                end
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        logic [18:0] want_addr [3];
        want_addr[0] = 19'h7FFFE; want_addr[1] = 19'h7FFFF; want_addr[2] = 19'h00000;
        drive(1'b0, 1'b1, 1'b1, 19'h7FFFE, 1'b1);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'b0, 19'h0, 1'b1);
            n_vec++;
            if (k < 3 && imem_addr_o !== want_addr[k]) begin
                n_err++;
                $display("FAIL wrap_addr[%0d]: addr=%h want %h", k, imem_addr_o, want_addr[k]);
            end
            n_vec++;
            if (k == 0 && (flush_o !== 1'b1 || if_valid_o !== 1'b0 || taken_cnt_o !== 16'd1)) begin
                n_err++;
                $display("FAIL wrap_flush: flush=%b valid=%b cnt=%0d, want 1/0/1", flush_o, if_valid_o, taken_cnt_o);
            end else if (k > 0 && (flush_o !== 1'b0 || if_valid_o !== 1'b1 || if_pc_o !== want_addr[k-1])) begin
                n_err++;
                $display("FAIL wrap_out[%0d]: flush=%b valid=%b pc=%h, want 0/1/%h", k, flush_o, if_valid_o, if_pc_o, want_addr[k-1]);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        // IF holds pc 00001 and the next request is 00002
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b0, 19'h0, 1'b1);
            n_vec++;
            if (imem_req_o !== 1'b0 || if_valid_o !== 1'b1 || if_pc_o !== 19'h00001 || if_instr_o !== mem_word(19'h00001)) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: req=%b valid=%b pc=%h instr=%h, want 0/1/00001/%h", k, imem_req_o, if_valid_o, if_pc_o, if_instr_o, mem_word(19'h00001));
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 19'h0, 1'b1);
        n_vec++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 19'h00002) begin
            n_err++;
            $display("FAIL stall_resume: req=%b addr=%h, want 1/00002", imem_req_o, imem_addr_o);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 19'h0, 1'b1);
        n_vec++;
        if (if_pc_o !== 19'h00002 || imem_addr_o !== 19'h00003) begin
            n_err++;
            $display("FAIL stall_next: pc=%h addr=%h, want 00002/00003", if_pc_o, imem_addr_o);
        end
        tick();
    endtask

    task automatic fetch_to_20();
        do_reset();
        for (int k = 0; k < 32; k++) begin
            drive(1'b0, 1'b0, 1'b0, 19'h0, 1'b1);
            tick();
        end
    endtask

    task automatic test_drain();
        logic [18:0] want_addr [4];
        logic        want_ack  [4];
        want_addr[0] = 19'h00020; want_addr[1] = 19'h00020; want_addr[2] = 19'h00020; want_addr[3] = 19'h00100;
        want_ack[0] = 1'b0; want_ack[1] = 1'b0; want_ack[2] = 1'b1; want_ack[3] = 1'b1;
        fetch_to_20();
        drive(1'b0, 1'b1, 1'b1, 19'h00100, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'b0, 19'h0, want_ack[k]);
            n_vec++;
            if (imem_req_o !== 1'b1 || imem_addr_o !== want_addr[k] || flush_o !== (k == 0) || if_valid_o !== 1'b0 || taken_cnt_o !== 16'd1) begin
                n_err++;
                $display("FAIL drain[%0d]: req=%b addr=%h flush=%b valid=%b cnt=%0d, want 1/%h/%b/0/1", k, imem_req_o, imem_addr_o, flush_o, if_valid_o, taken_cnt_o, want_addr[k], (k == 0));
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 19'h0, 1'b1);
        n_vec++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 19'h00100 || if_instr_o !== mem_word(19'h00100)) begin
            n_err++;
            $display("FAIL drain_target: valid=%b pc=%h instr=%h, want 1/00100/%h", if_valid_o, if_pc_o, if_instr_o, mem_word(19'h00100));
        end
        tick();
    endtask

    task automatic test_double_redirect();
        fetch_to_20();
        drive(1'b0, 1'b1, 1'b1, 19'h00100, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 19'h00200, 1'b0);
        n_vec++;
        if (flush_o !== 1'b1 || imem_addr_o !== 19'h00020) begin
            n_err++;
            $display("FAIL dbl_first: flush=%b addr=%h, want 1/00020", flush_o, imem_addr_o);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 19'h0, 1'b1);
        n_vec++;
        if (flush_o !== 1'b1 || imem_addr_o !== 19'h00020 || taken_cnt_o !== 16'd2) begin
            n_err++;
            $display("FAIL dbl_second: flush=%b addr=%h cnt=%0d, want 1/00020/2", flush_o, imem_addr_o, taken_cnt_o);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 19'h0, 1'b1);
        n_vec++;
        if (flush_o !== 1'b0 || imem_addr_o !== 19'h00200 || if_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL dbl_target: flush=%b addr=%h valid=%b, want 0/00200/0", flush_o, imem_addr_o, if_valid_o);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 19'h0, 1'b1);
        n_vec++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 19'h00200 || taken_cnt_o !== 16'd2) begin
            n_err++;
            $display("FAIL dbl_fetch: valid=%b pc=%h cnt=%0d, want 1/00200/2", if_valid_o, if_pc_o, taken_cnt_o);
        end
        tick();
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0, 19'h0, 1'b1);
            tick();
        end
        drive(1'b0, 1'b1, 1'b1, 19'h00100, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 19'h0, 1'b0);
        n_vec++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 19'h00003) begin
            n_err++;
            $display("FAIL rst_drain_pre: req=%b addr=%h, want 1/00003", imem_req_o, imem_addr_o);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (imem_req_o !== 1'b0 || imem_addr_o !== 19'h00000 || flush_o !== 1'b0 || if_valid_o !== 1'b0 || taken_cnt_o !== 16'h0) begin
            n_err++;
            $display("FAIL rst_async: req=%b addr=%h flush=%b valid=%b cnt=%0d, want 0/00000/0/0/0", imem_req_o, imem_addr_o, flush_o, if_valid_o, taken_cnt_o);
        end
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 19'h0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 19'h0, 1'b1);
        n_vec++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 19'h00000) begin
            n_err++;
            $display("FAIL rst_restart: req=%b addr=%h, want 1/00000", imem_req_o, imem_addr_o);
        end
        tick();
    endtask

    task automatic test_saturate();
        do_reset();
        for (int k = 0; k <= 20; k++) begin
            drive(1'b0, 1'b1, 1'b1, 19'($urandom), 1'b1);
            n_vec++;
            if (cnt4 !== ((k > 15) ? 4'hF : 4'(k)) || taken_cnt_o !== 16'(k)) begin
                n_err++;
                $display("FAIL sat_cnt[%0d]: cnt4=%0d cnt16=%0d, want %0d/%0d", k, cnt4, taken_cnt_o, (k > 15) ? 15 : k, k);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic        s, bv, bt, ae;
        logic [18:0] tgt;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            s   = ($urandom_range(0, 3) == 0);
            bv  = ($urandom_range(0, 7) == 0);
            bt  = $urandom_range(0, 1) == 1;
            ae  = ($urandom_range(0, 3) != 0);
            tgt = ($urandom_range(0, 3) == 0) ? (19'h7FFFC + 19'($urandom_range(0, 3))) : 19'($urandom);
            drive(s, bv, bt, tgt, ae);
            n_vec++;
            if (imem_req_o !== exp_req() || imem_addr_o !== exp_addr() || req4 !== exp_req() || addr4 !== exp_addr()) begin
                n_err++;
                $display("FAIL rnd_req[%0d]: req=%b addr=%h req4=%b addr4=%h, want %b/%h", c, imem_req_o, imem_addr_o, req4, addr4, exp_req(), exp_addr());
            end
            n_vec++;
            if (if_valid_o !== m_valid || flush_o !== m_flush || valid4 !== m_valid || flush4 !== m_flush) begin
                n_err++;
                $display("FAIL rnd_ctl[%0d]: valid=%b flush=%b valid4=%b flush4=%b, want %b/%b", c, if_valid_o, flush_o, valid4, flush4, m_valid, m_flush);
            end
            n_vec++;
            if (taken_cnt_o !== exp_cnt16() || cnt4 !== exp_cnt4()) begin
                n_err++;
                $display("FAIL rnd_cnt[%0d]: cnt=%0d cnt4=%0d, want %0d/%0d", c, taken_cnt_o, cnt4, exp_cnt16(), exp_cnt4());
            end
            if (m_valid) begin
                n_vec++;
                if (if_pc_o !== m_ifpc || if_instr_o !== m_instr || pc4 !== m_ifpc || instr4 !== m_instr) begin
                    n_err++;
                    $display("FAIL rnd_data[%0d]: pc=%h instr=%h pc4=%h instr4=%h, want %h/%h", c, if_pc_o, if_instr_o, pc4, instr4, m_ifpc, m_instr);
                end
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; stall_i = 1'b0; br_valid_i = 1'b0; br_taken_i = 1'b0;
        br_target_i = 19'h0; imem_ack_i = 1'b0; imem_rdata_i = 32'h0; ack_en = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_seq_fetch();
        test_wrap();
        test_stall();
        test_drain();
        test_double_redirect();
        test_reset_mid_drain();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
